// File: rtl/branch_cmp_unit.sv
// Registered branch resolver: eight compare modes, valid/ready handshake,
// 2-bit-counter branch history table for fetch prediction, and mispredict stats.
module branch_cmp_unit #(
  parameter int WIDTH    = 32,
  parameter int BHT_BITS = 6,
  parameter int PC_LSB   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pred_pc,
  output logic             pred_taken,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_mode,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [31:0]      req_pc,
  input  logic             req_pred,
  input  logic             flush,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_taken,
  output logic             rsp_mispredict,
  output logic [31:0]      rsp_pc,
  output logic [31:0]      stat_branches,
  output logic [31:0]      stat_misses
);

  localparam int DEPTH = 1 << BHT_BITS;

  function automatic logic resolve(input logic [2:0] mode,
                                   input logic [WIDTH-1:0] a,
                                   input logic [WIDTH-1:0] b);
    logic r;
    case (mode)
      3'd0:    r = (a == b);
      3'd1:    r = (a != b);
      3'd2:    r = ($signed(a) <= $signed({WIDTH{1'b0}}));
      3'd3:    r = ($signed(a) >  $signed({WIDTH{1'b0}}));
      3'd4:    r = a[WIDTH-1];
      3'd5:    r = ~a[WIDTH-1];
      3'd6:    r = ($signed(a) < $signed(b));
      3'd7:    r = (a < b);
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  // Saturating 2-bit counter step: up on taken, down on not-taken.
  function automatic logic [1:0] ctr_next(input logic [1:0] c, input logic t);
    logic [1:0] n;
    case ({t, c})
      3'b1_11: n = 2'd3;
      3'b0_00: n = 2'd0;
      default: n = t ? (c + 2'd1) : (c - 2'd1);
    endcase
    return n;
  endfunction

  logic                rsp_valid_q, rsp_valid_d;
  logic                rsp_taken_q, rsp_taken_d;
  logic                rsp_mis_q, rsp_mis_d;
  logic [31:0]         rsp_pc_q, rsp_pc_d;
  logic [31:0]         branches_q, branches_d;
  logic [31:0]         misses_q, misses_d;
  logic [1:0]          bht_q [DEPTH];
  logic [1:0]          bht_d [DEPTH];

  logic                accept_s;
  logic                taken_s;
  logic [BHT_BITS-1:0] req_idx_s;
  logic [BHT_BITS-1:0] pred_idx_s;
  logic                pc_unused_s;

  assign req_ready   = ~rsp_valid_q | rsp_ready;
  assign accept_s    = req_valid & req_ready & ~flush;
  assign taken_s     = resolve(req_mode, req_a, req_b);
  assign req_idx_s   = req_pc[PC_LSB +: BHT_BITS];
  assign pred_idx_s  = pred_pc[PC_LSB +: BHT_BITS];
  // Lookup reads the registered table, so a same-cycle update is not forwarded.
  assign pred_taken  = bht_q[pred_idx_s][1];
  assign pc_unused_s = ^{pred_pc, req_pc};

  assign rsp_valid      = rsp_valid_q;
  assign rsp_taken      = rsp_taken_q;
  assign rsp_mispredict = rsp_mis_q;
  assign rsp_pc         = rsp_pc_q;
  assign stat_branches  = branches_q;
  assign stat_misses    = misses_q;

  // Result register next state: flush wins, then accept, then consume.
  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_taken_d = rsp_taken_q;
    rsp_mis_d   = rsp_mis_q;
    rsp_pc_d    = rsp_pc_q;
    if (flush) begin
      rsp_valid_d = 1'b0;
    end else if (accept_s) begin
      rsp_valid_d = 1'b1;
      rsp_taken_d = taken_s;
      rsp_mis_d   = taken_s ^ req_pred;
      rsp_pc_d    = req_pc;
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end else begin
      rsp_valid_d = rsp_valid_q;
    end
  end

  // Saturating statistics counters.
  always_comb begin
    branches_d = branches_q;
    misses_d   = misses_q;
    if (accept_s) begin
      if (branches_q != 32'hFFFF_FFFF) begin
        branches_d = branches_q + 32'd1;
      end else begin
        branches_d = branches_q;
      end
      if ((taken_s ^ req_pred) && (misses_q != 32'hFFFF_FFFF)) begin
        misses_d = misses_q + 32'd1;
      end else begin
        misses_d = misses_q;
      end
    end else begin
      branches_d = branches_q;
      misses_d   = misses_q;
    end
  end

  // Branch history table update for the accepted branch.
  always_comb begin
    bht_d = bht_q;
    if (accept_s) begin
      bht_d[req_idx_s] = ctr_next(bht_q[req_idx_s], taken_s);
    end else begin
      bht_d = bht_q;
    end
  end

  // State registers; reset leaves every history counter weakly not-taken.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rsp_valid_q <= 1'b0;
      rsp_taken_q <= 1'b0;
      rsp_mis_q   <= 1'b0;
      rsp_pc_q    <= 32'd0;
      branches_q  <= 32'd0;
      misses_q    <= 32'd0;
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= 2'b01;
      end
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_taken_q <= rsp_taken_d;
      rsp_mis_q   <= rsp_mis_d;
      rsp_pc_q    <= rsp_pc_d;
      branches_q  <= branches_d;
      misses_q    <= misses_d;
      for (int i = 0; i < DEPTH; i++) begin
        bht_q[i] <= bht_d[i];
      end
    end
  end

endmodule

// File: doc/branch_cmp_unit.md
Name: branch_cmp_unit

Overview:
- Parametrised, registered successor to the combinational branch comparator.
- Resolves one conditional branch per accepted request across eight compare modes.
- Keeps a 2-bit-counter branch history table (BHT) that serves the fetch-stage prediction, and flags mispredicts.
- Sits between the decode/ID operand forwarding muxes and the PC-select logic; a valid/ready handshake lets the hazard unit stall it.

Parameters:
- WIDTH, 32, operand width in bits.
- BHT_BITS, 6, log2 of BHT depth (64 entries).
- PC_LSB, 2, lowest PC bit used for the BHT index.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- pred_pc  in  32  fetch-stage PC for prediction lookup.
- pred_taken  out  1  prediction for pred_pc (MSB of the indexed counter; combinational).
- req_valid  in  1  branch request present.
- req_ready  out  1  unit can accept a request this cycle.
- req_mode  in  3  compare mode, encoded below.
- req_a  in  WIDTH  operand A (rs).
- req_b  in  WIDTH  operand B (rt); ignored by the compare-to-zero modes.
- req_pc  in  32  PC of the branch.
- req_pred  in  1  prediction used at fetch for this branch.
- flush  in  1  kill the in-flight result and any request presented this cycle.
- rsp_valid  out  1  result register holds a valid result.
- rsp_ready  in  1  consumer takes the result.
- rsp_taken  out  1  resolved direction.
- rsp_mispredict  out  1  rsp_taken differs from the prediction captured with the request.
- rsp_pc  out  32  PC of the resolved branch.
- stat_branches  out  32  count of accepted branches.
- stat_misses  out  32  count of accepted mispredicted branches.

Behaviour:
- Modes (a, b as WIDTH-bit values):
  - 0 EQ: a==b.
  - 1 NE: a!=b.
  - 2 LEZ: signed a<=0.
  - 3 GTZ: signed a>0.
  - 4 LTZ: a[WIDTH-1]==1.
  - 5 GEZ: a[WIDTH-1]==0.
  - 6 LT: signed a<b.
  - 7 LTU: unsigned a<b.
- Handshake:
  - req_ready = !rsp_valid | rsp_ready.
  - Accept = req_valid & req_ready & !flush.
  - Response: rsp_valid rises one edge after accept, and holds with all rsp_* stable until rsp_ready=1.
  - Back-to-back accepts allowed when rsp_ready=1 every cycle (throughput 1 per cycle, latency 1).
- On accept, the result register loads: taken, mispredict = taken ^ req_pred, and req_pc.
- When rsp_valid & rsp_ready and there is no accept, rsp_valid clears.
- flush has priority: the next edge clears rsp_valid; the request in the same cycle is dropped with no BHT or stat update. rsp_taken, rsp_mispredict and rsp_pc keep their values (don't-care while rsp_valid=0).
- BHT:
  - Index = pc[PC_LSB+BHT_BITS-1:PC_LSB].
  - On accept, the counter at the req_pc index moves up 1 if taken, down 1 otherwise.
  - Saturates at 3 and 0.
- BHT read-during-write: a pred_pc lookup to the index being updated returns the pre-update value; the new value is visible the cycle after the edge.
- Stats: on accept, stat_branches +1 and stat_misses +1 if mispredicted. Both saturate at 32'hFFFFFFFF, with no wrap.
- Reset (async, reset=0):
  - rsp_valid=0, rsp_taken=0, rsp_mispredict=0, rsp_pc=0.
  - stat_branches=0, stat_misses=0.
  - All BHT counters = 2'b01 (weakly not-taken), so pred_taken=0.
  - An in-flight result is lost.
  - req_ready=1 while in reset and after release.
- Release: the first accept is possible on the first rising edge with reset=1.

Test Plan:
- Reset, then pred_pc=0x00003000 -> pred_taken=0, rsp_valid=0, both stats 0, req_ready=1.
- Mode sweep, a=0xFFFFFFFF, b=0x00000001, rsp_ready=1:
  - EQ=0, NE=1, LEZ=1, GTZ=0, LTZ=1, GEZ=0, LT=1, LTU=0.
  - Each result appears one cycle after accept.
- Same req_pc=0x00003010, taken, req_pred=0, accepted 3 times:
  - Mispredict=1 each time; stat_misses=3.
  - BHT index 4: counter 01->10->11->11.
  - pred_pc=0x00003010 gives pred_taken=1 from the cycle after the first update.
- Stall: rsp_ready=0 with rsp_valid=1 and a new req_valid=1 -> req_ready=0, rsp_* held unchanged for 3 cycles. Raising rsp_ready accepts the pending request next edge.
- Flush with req_valid=1 and rsp_valid=1 -> next cycle rsp_valid=0, stats and BHT unchanged.
- Async reset asserted mid-cycle while rsp_valid=1 -> rsp_valid=0 immediately, before the next clk edge. Stats clear and BHT entries return to 01.
